sync_debounce: RTL



---
 rtl/sync_pkg.sv | 16 +
 rtl/debounce_channel.sv | 80 ++++++++
 rtl/sync_debounce.sv | 37 +++
 3 files changed

// File: rtl/sync_pkg.sv
// Shared constants and helpers for the input-conditioning blocks.
package sync_pkg;

  localparam int unsigned SYNC_STAGES_MIN = 2;

  // Ceiling log2; returns the bit count needed to index `value` distinct states.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: synchronizer chain, counter-based debounce filter and edge pulses.
module debounce_channel
  import sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 4,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in,
  output logic level,
  output logic rise,
  output logic fall
);

  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
    $error("debounce_channel: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE < 1) begin : g_bad_debounce
    $error("debounce_channel: DEBOUNCE must be at least 1");
  end

  localparam int unsigned     CntW    = clog2(DEBOUNCE + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Plain shift register: stage0 is the only flop sampling asynchronous data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CntLast) begin
      level_d = s;
      cnt_d   = '0;
      rise_d  = s;
      fall_d  = ~s;
    end else begin
      cnt_d = cnt_q + CntW'(1'b1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      level_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/sync_debounce.sv
// Multi-channel synchronizer + debounce filter with registered rise/fall pulses.
module sync_debounce
  import sync_pkg::*;
#(
  parameter int unsigned       NUM_CH      = 1,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter int unsigned       DEBOUNCE    = 4,
  parameter logic [NUM_CH-1:0] RESET_VAL   = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] in,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall
);

  if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
    $error("sync_debounce: SYNC_STAGES must be at least 2");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE    (DEBOUNCE),
      .RESET_VAL   (RESET_VAL[i])
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .in      (in[i]),
      .level   (level[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

endmodule
